csr_bank: RTL and testbench

- Machine-mode CSR file and trap controller for the RV32I core.
- Sits downstream of decode, next to execute.
  - Consumes the CSR operation (NONE/WRITE/SET/CLEAR), CSR address, exception codes and interrupt codes produced by decode/execute.
  - Produces read data, illegal-access flags, pending-interrupt requests and the registered jump target for trap entry and MRET.
- Owns mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip, and the 64-bit cycle/instret counters.

---
 rtl/csr_bank.sv | 273 +++++++++++++++++++++++++++
 tb/tb_csr_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_bank.sv
// Machine-mode CSR file and trap controller for an RV32I core.
// Holds the M-mode trap CSRs and the 64-bit counters, and issues the trap/MRET fetch redirect.
module csr_bank #(
  parameter logic [31:0] HARTID      = 32'h0000_0000,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        instr_retired_i,
  input  logic        exception_i,
  input  logic [4:0]  exception_code_i,
  input  logic [31:0] exception_pc_i,
  input  logic [31:0] exception_tval_i,
  input  logic        mret_i,
  input  logic        irq_sw_i,
  input  logic        irq_tim_i,
  input  logic        irq_ext_i,
  output logic        interrupt_pending_o,
  input  logic        interrupt_ack_i,
  input  logic [31:0] interrupt_pc_i,
  output logic        jump_o,
  output logic [31:0] jump_target_o,
  output logic [1:0]  privilege_o
);

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS    = 12'h300;
  localparam logic [11:0] ADDR_MISA       = 12'h301;
  localparam logic [11:0] ADDR_MEDELEG    = 12'h302;
  localparam logic [11:0] ADDR_MIDELEG    = 12'h303;
  localparam logic [11:0] ADDR_MIE        = 12'h304;
  localparam logic [11:0] ADDR_MTVEC      = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTEREN = 12'h306;
  localparam logic [11:0] ADDR_MSTATUSH   = 12'h310;
  localparam logic [11:0] ADDR_MSCRATCH   = 12'h340;
  localparam logic [11:0] ADDR_MEPC       = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE     = 12'h342;
  localparam logic [11:0] ADDR_MTVAL      = 12'h343;
  localparam logic [11:0] ADDR_MIP        = 12'h344;
  localparam logic [11:0] ADDR_MTINST     = 12'h34A;
  localparam logic [11:0] ADDR_MTVAL2     = 12'h34B;
  localparam logic [11:0] ADDR_MVENDORID  = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID    = 12'hF12;
  localparam logic [11:0] ADDR_MIMPID     = 12'hF13;
  localparam logic [11:0] ADDR_MHARTID    = 12'hF14;
  localparam logic [11:0] ADDR_MCONFIGPTR = 12'hF15;
  localparam logic [11:0] ADDR_CYCLE      = 12'hC00;
  localparam logic [11:0] ADDR_TIME       = 12'hC01;
  localparam logic [11:0] ADDR_INSTRET    = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH     = 12'hC80;
  localparam logic [11:0] ADDR_TIMEH      = 12'hC81;
  localparam logic [11:0] ADDR_INSTRETH   = 12'hC82;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Fixed-priority pick among enabled pending lines {ext, tim, sw}: ext > sw > tim.
  function automatic logic [4:0] irq_code(input logic [2:0] active);
    logic [4:0] code;
    if (active[2]) begin
      code = 5'd11;
    end else if (active[0]) begin
      code = 5'd3;
    end else if (active[1]) begin
      code = 5'd7;
    end else begin
      code = 5'd0;
    end
    return code;
  endfunction

  csr_op_e     op_s;
  logic        mstatus_mie_r;
  logic        mstatus_mpie_r;
  logic [2:0]  mie_r;
  logic [2:0]  mip_r;
  logic [31:0] mtvec_r;
  logic [31:0] mscratch_r;
  logic [31:0] mepc_r;
  logic [31:0] mcause_r;
  logic [31:0] mtval_r;
  logic [63:0] cycle_r;
  logic [63:0] instret_r;
  logic        pending_r;
  logic [4:0]  pending_code_r;
  logic        jump_r;
  logic [31:0] jump_target_r;

  logic [31:0] mstatus_s;
  logic [31:0] mie_val_s;
  logic [31:0] mip_val_s;
  logic [31:0] rdata_s;
  logic        addr_valid_s;
  logic        wen_s;
  logic [31:0] wval_s;
  logic        illegal_s;
  logic        exc_take_s;
  logic        irq_take_s;
  logic        mret_take_s;
  logic        csr_commit_s;
  logic [2:0]  irq_act_s;
  logic [31:0] trap_base_s;
  logic [31:0] trap_target_s;

  assign op_s      = csr_op_e'(csr_op_i);
  assign mstatus_s = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
  assign mie_val_s = {20'd0, mie_r[2], 3'd0, mie_r[1], 3'd0, mie_r[0], 3'd0};
  assign mip_val_s = {20'd0, mip_r[2], 3'd0, mip_r[1], 3'd0, mip_r[0], 3'd0};
  assign irq_act_s = mip_r & mie_r;

  // Read mux and address decode for the implemented CSRs
  always_comb begin
    rdata_s      = 32'h0000_0000;
    addr_valid_s = 1'b1;
    case (csr_addr_i)
      ADDR_MSTATUS:  rdata_s = mstatus_s;
      ADDR_MISA:     rdata_s = MISA_VALUE;
      ADDR_MIE:      rdata_s = mie_val_s;
      ADDR_MTVEC:    rdata_s = mtvec_r;
      ADDR_MSCRATCH: rdata_s = mscratch_r;
      ADDR_MEPC:     rdata_s = mepc_r;
      ADDR_MCAUSE:   rdata_s = mcause_r;
      ADDR_MTVAL:    rdata_s = mtval_r;
      ADDR_MIP:      rdata_s = mip_val_s;
      ADDR_MHARTID:  rdata_s = HARTID;
      ADDR_MEDELEG, ADDR_MIDELEG, ADDR_MCOUNTEREN, ADDR_MSTATUSH,
      ADDR_MTINST, ADDR_MTVAL2, ADDR_MVENDORID, ADDR_MARCHID,
      ADDR_MIMPID, ADDR_MCONFIGPTR: rdata_s = 32'h0000_0000;
      ADDR_CYCLE, ADDR_TIME:   rdata_s = cycle_r[31:0];
      ADDR_CYCLEH, ADDR_TIMEH: rdata_s = cycle_r[63:32];
      ADDR_INSTRET:  rdata_s = instret_r[31:0];
      ADDR_INSTRETH: rdata_s = instret_r[63:32];
      default:       addr_valid_s = 1'b0;
    endcase
  end

  // Write enable and read-modify-write value; SET/CLEAR with a zero mask are pure reads
  always_comb begin
    wen_s  = 1'b0;
    wval_s = rdata_s;
    case (op_s)
      OP_WRITE: begin
        wen_s  = 1'b1;
        wval_s = csr_wdata_i;
      end
      OP_SET: begin
        wen_s  = |csr_wdata_i;
        wval_s = rdata_s | csr_wdata_i;
      end
      OP_CLEAR: begin
        wen_s  = |csr_wdata_i;
        wval_s = rdata_s & ~csr_wdata_i;
      end
      default: begin
        wen_s  = 1'b0;
        wval_s = rdata_s;
      end
    endcase
  end

  assign illegal_s    = (op_s != OP_NONE) &&
                        (!addr_valid_s || (wen_s && (csr_addr_i[11:10] == 2'b11)));
  assign exc_take_s   = exception_i;
  assign irq_take_s   = !exception_i && interrupt_ack_i && pending_r;
  assign mret_take_s  = !exception_i && !irq_take_s && mret_i;
  assign csr_commit_s = wen_s && !illegal_s && !exc_take_s && !irq_take_s && !mret_take_s;
  assign trap_base_s  = {mtvec_r[31:2], 2'b00};

  // Trap vector: interrupts in vectored mode land at BASE + 4*cause
  always_comb begin
    if (irq_take_s && (mtvec_r[1:0] == 2'b01)) begin
      trap_target_s = trap_base_s + {25'd0, pending_code_r, 2'b00};
    end else begin
      trap_target_s = trap_base_s;
    end
  end

  // Architectural CSR state: trap entry beats MRET, which beats a software write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_r          <= 3'b000;
      mtvec_r        <= MTVEC_RESET;
      mscratch_r     <= 32'h0000_0000;
      mepc_r         <= 32'h0000_0000;
      mcause_r       <= 32'h0000_0000;
      mtval_r        <= 32'h0000_0000;
    end else if (exc_take_s || irq_take_s) begin
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
      mepc_r         <= (exc_take_s ? exception_pc_i : interrupt_pc_i) & ALIGN_MASK;
      mcause_r       <= exc_take_s ? {1'b0, 26'd0, exception_code_i}
                                   : {1'b1, 26'd0, pending_code_r};
      mtval_r        <= exc_take_s ? exception_tval_i : 32'h0000_0000;
    end else if (mret_take_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (csr_commit_s) begin
      case (csr_addr_i)
        ADDR_MSTATUS: begin
          mstatus_mie_r  <= wval_s[3];
          mstatus_mpie_r <= wval_s[7];
        end
        ADDR_MIE:      mie_r      <= {wval_s[11], wval_s[7], wval_s[3]};
        ADDR_MTVEC:    mtvec_r    <= {wval_s[31:2], wval_s[1] ? mtvec_r[1:0] : wval_s[1:0]};
        ADDR_MSCRATCH: mscratch_r <= wval_s;
        ADDR_MEPC:     mepc_r     <= wval_s & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_r   <= wval_s;
        ADDR_MTVAL:    mtval_r    <= wval_s;
        default: ;
      endcase
    end
  end

  // Interrupt sampling; pending is withdrawn in the cycle a trap is taken so it cannot be acked twice
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mip_r          <= 3'b000;
      pending_r      <= 1'b0;
      pending_code_r <= 5'd0;
    end else begin
      mip_r          <= {irq_ext_i, irq_tim_i, irq_sw_i};
      pending_r      <= mstatus_mie_r && (|irq_act_s) && !(exc_take_s || irq_take_s);
      pending_code_r <= irq_code(irq_act_s);
    end
  end

  // Free-running 64-bit counters, assigned every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
    end else begin
      cycle_r   <= cycle_r + 64'd1;
      instret_r <= instret_r + {63'd0, instr_retired_i};
    end
  end

  // Registered fetch redirect, one pulse per trap or MRET
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jump_r        <= 1'b0;
      jump_target_r <= 32'h0000_0000;
    end else begin
      jump_r <= exc_take_s || irq_take_s || mret_take_s;
      if (exc_take_s || irq_take_s) begin
        jump_target_r <= trap_target_s;
      end else if (mret_take_s) begin
        jump_target_r <= mepc_r;
      end
    end
  end

  assign csr_rdata_o         = rdata_s;
  assign csr_illegal_o       = illegal_s;
  assign interrupt_pending_o = pending_r;
  assign jump_o              = jump_r;
  assign jump_target_o       = jump_target_r;
  assign privilege_o         = 2'b11;

endmodule

// File: tb/tb_csr_bank.sv
// Scoreboard bench for csr_bank: CSR access, counters, interrupt/exception entry and MRET.
module tb_csr_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  csr_op_i = 2'd0;
  logic [11:0] csr_addr_i = 12'h000;
  logic [31:0] csr_wdata_i = 32'd0;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        instr_retired_i = 1'b0;
  logic        exception_i = 1'b0;
  logic [4:0]  exception_code_i = 5'd0;
  logic [31:0] exception_pc_i = 32'd0;
  logic [31:0] exception_tval_i = 32'd0;
  logic        mret_i = 1'b0;
  logic        irq_sw_i = 1'b0;
  logic        irq_tim_i = 1'b0;
  logic        irq_ext_i = 1'b0;
  logic        interrupt_pending_o;
  logic        interrupt_ack_i = 1'b0;
  logic [31:0] interrupt_pc_i = 32'd0;
  logic        jump_o;
  logic [31:0] jump_target_o;
  logic [1:0]  privilege_o;

  localparam logic [1:0] NONE = 2'd0, WRITE = 2'd1, SET = 2'd2, CLEAR = 2'd3;

  csr_bank dut (
    .clk(clk), .reset(reset),
    .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instr_retired_i(instr_retired_i),
    .exception_i(exception_i), .exception_code_i(exception_code_i),
    .exception_pc_i(exception_pc_i), .exception_tval_i(exception_tval_i),
    .mret_i(mret_i),
    .irq_sw_i(irq_sw_i), .irq_tim_i(irq_tim_i), .irq_ext_i(irq_ext_i),
    .interrupt_pending_o(interrupt_pending_o), .interrupt_ack_i(interrupt_ack_i),
    .interrupt_pc_i(interrupt_pc_i),
    .jump_o(jump_o), .jump_target_o(jump_target_o), .privilege_o(privilege_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] jump_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] tb_cyc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    sb_t e;
    e = sb_q.pop_front();
    check_eq(e.tag, obs, e.val);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op_i   = NONE;
    csr_addr_i = addr;
    #1;
    push_exp(tag, exp);
    pop_chk(csr_rdata_o);
    push_exp({tag, "_ill"}, 32'd0);
    pop_chk({31'd0, csr_illegal_o});
    step();
  endtask

  task automatic csr(input string tag, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wdata, input logic exp_ill);
    csr_op_i    = op;
    csr_addr_i  = addr;
    csr_wdata_i = wdata;
    #1;
    push_exp(tag, {31'd0, exp_ill});
    pop_chk({31'd0, csr_illegal_o});
    step();
    csr_op_i    = NONE;
    csr_wdata_i = 32'd0;
  endtask

  // Reference cycle count since reset release
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= 64'd0;
    else       tb_cyc <= tb_cyc + 64'd1;
  end

  // Every jump pulse must match the next queued redirect
  always @(negedge clk) begin
    if (!reset && jump_o) begin
      if (jump_q.size() == 0) check_eq("jump_unexpected", {31'd0, jump_o}, 32'd0);
      else                    check_eq("jump_target", jump_target_o, jump_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check_eq("rst_jump", {31'd0, jump_o}, 32'd0);
    check_eq("rst_target", jump_target_o, 32'd0);
    check_eq("rst_pending", {31'd0, interrupt_pending_o}, 32'd0);
    check_eq("priv", {30'd0, privilege_o}, 32'd3);
    rd("misa", 12'h301, 32'h4000_0100);
    rd("mhartid", 12'hF14, 32'd0);
    rd("mtvec_rst", 12'h305, 32'd0);
    rd("mstatus_rst", 12'h300, 32'h0000_1800);
    rd("mepc_rst", 12'h341, 32'd0);
    rd("instret_rst", 12'hC02, 32'd0);

    csr("ms_set8", SET, 12'h300, 32'h8, 1'b0);
    rd("ms_a", 12'h300, 32'h0000_1808);
    csr("ms_clr8", CLEAR, 12'h300, 32'h8, 1'b0);
    rd("ms_b", 12'h300, 32'h0000_1800);
    csr("ms_set0", SET, 12'h300, 32'h0, 1'b0);
    rd("ms_c", 12'h300, 32'h0000_1800);

    csr("cyc_wr", WRITE, 12'hC00, 32'h1234, 1'b1);
    rd("cyc_val", 12'hC00, tb_cyc[31:0]);
    rd("cych_val", 12'hC80, tb_cyc[63:32]);
    csr("cyc_set0", SET, 12'hC00, 32'h0, 1'b0);
    csr("bad_wr", WRITE, 12'h7C0, 32'h5, 1'b1);
    csr("bad_set0", SET, 12'h7C0, 32'h0, 1'b1);
    csr("bad_clr", CLEAR, 12'h7C0, 32'h5, 1'b1);

    csr("mscr_wr", WRITE, 12'h340, 32'h0000_A5A5, 1'b0);
    rd("mscr", 12'h340, 32'h0000_A5A5);
    csr("mtvec_mode3", WRITE, 12'h305, 32'h0000_0103, 1'b0);
    rd("mtvec_warl", 12'h305, 32'h0000_0100);
    csr("mtvec_vec", WRITE, 12'h305, 32'h0000_0101, 1'b0);
    rd("mtvec_v", 12'h305, 32'h0000_0101);
    csr("mepc_wr", WRITE, 12'h341, 32'h0000_1237, 1'b0);
    rd("mepc_align", 12'h341, 32'h0000_1234);
    csr("mie_all", WRITE, 12'h304, 32'hFFFF_FFFF, 1'b0);
    rd("mie_mask", 12'h304, 32'h0000_0888);
    csr("mip_wr", WRITE, 12'h344, 32'hFFFF_FFFF, 1'b0);
    rd("mip_ro", 12'h344, 32'd0);

    instr_retired_i = 1'b0;
    force dut.instret_r = 64'h0000_0000_FFFF_FFFF;
    step();
    release dut.instret_r;
    instr_retired_i = 1'b1;
    step();
    step();
    instr_retired_i = 1'b0;
    rd("instreth", 12'hC82, 32'd1);
    rd("instret", 12'hC02, 32'd1);

    csr("mie_tim", WRITE, 12'h304, 32'h80, 1'b0);
    csr("mie_on", SET, 12'h300, 32'h8, 1'b0);
    irq_tim_i = 1'b1;
    step();
    check_eq("pend_early", {31'd0, interrupt_pending_o}, 32'd0);
    step();
    check_eq("pend_tim", {31'd0, interrupt_pending_o}, 32'd1);
    interrupt_ack_i = 1'b1;
    interrupt_pc_i  = 32'h2000;
    jump_q.push_back(32'h0000_011C);
    step();
    interrupt_ack_i = 1'b0;
    check_eq("irq_jump", {31'd0, jump_o}, 32'd1);
    rd("irq_mcause", 12'h342, 32'h8000_0007);
    check_eq("irq_jump_off", {31'd0, jump_o}, 32'd0);
    rd("irq_mepc", 12'h341, 32'h0000_2000);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    rd("irq_mtval", 12'h343, 32'd0);
    check_eq("pend_after", {31'd0, interrupt_pending_o}, 32'd0);

    irq_tim_i = 1'b0;
    interrupt_ack_i = 1'b1;
    step();
    interrupt_ack_i = 1'b0;
    rd("ack_ignored", 12'h342, 32'h8000_0007);

    csr("mie_888", WRITE, 12'h304, 32'h888, 1'b0);
    {irq_ext_i, irq_tim_i, irq_sw_i} = 3'b111;
    csr("mie_on2", SET, 12'h300, 32'h8, 1'b0);
    step();
    step();
    check_eq("pend_all", {31'd0, interrupt_pending_o}, 32'd1);
    interrupt_ack_i = 1'b1;
    interrupt_pc_i  = 32'h3000;
    jump_q.push_back(32'h0000_012C);
    step();
    interrupt_ack_i = 1'b0;
    {irq_ext_i, irq_tim_i, irq_sw_i} = 3'b000;
    rd("prio_mcause", 12'h342, 32'h8000_000B);
    csr("mie_off", WRITE, 12'h304, 32'h0, 1'b0);
    csr("mie_on3", SET, 12'h300, 32'h8, 1'b0);
    rd("ms_pre_exc", 12'h300, 32'h0000_1888);

    exception_i      = 1'b1;
    exception_code_i = 5'd2;
    exception_pc_i   = 32'h400;
    exception_tval_i = 32'hDEAD;
    mret_i           = 1'b1;
    csr_op_i         = WRITE;
    csr_addr_i       = 12'h340;
    csr_wdata_i      = 32'h1111;
    jump_q.push_back(32'h0000_0100);
    step();
    exception_i = 1'b0;
    mret_i      = 1'b0;
    csr_op_i    = NONE;
    csr_wdata_i = 32'd0;
    rd("exc_mcause", 12'h342, 32'd2);
    rd("exc_mtval", 12'h343, 32'h0000_DEAD);
    rd("exc_mepc", 12'h341, 32'h0000_0400);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);
    rd("exc_mscr", 12'h340, 32'h0000_A5A5);

    mret_i = 1'b1;
    jump_q.push_back(32'h0000_0400);
    step();
    mret_i = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    mret_i = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_eq("rst2_jump", {31'd0, jump_o}, 32'd0);
    rd("rst2_mscr", 12'h340, 32'd0);
    rd("rst2_mtvec", 12'h305, 32'd0);
    rd("rst2_mstatus", 12'h300, 32'h0000_1800);
    rd("rst2_cyc", 12'hC00, tb_cyc[31:0]);

    check_eq("jump_q_left", jump_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
